// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    localparam int unsigned DIV_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((32'd1 << res) < value) begin
            res = res + 1;
        end
        if (res == 0) begin
            res = 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/cla_subtractor.sv
// N-bit subtractor a - b built as a + ~b + 1 from chained 4-bit lookahead slices.
// carry_out = 1 means no borrow (a >= b).
module cla_subtractor #(
    parameter int unsigned N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         carry_out
);

    logic [N-1:0] b_inv;
    logic [N-1:0] gen;
    logic [N-1:0] prop;
    logic [N:0]   carry;

    assign b_inv = ~b;
    assign gen   = a & b_inv;
    assign prop  = a ^ b_inv;

    // Per-slice group generate/propagate prefixes; each bit's carry is one AND-OR
    // away from its slice carry-in, and slice carry-ins chain slice to slice.
    always_comb begin
        logic grp_g;
        logic grp_p;
        logic slice_c;
        grp_g    = 1'b0;
        grp_p    = 1'b1;
        slice_c  = 1'b1;
        carry    = '0;
        carry[0] = 1'b1;
        for (int j = 0; j < int'(N); j++) begin
            if ((j % 4) == 0) begin
                slice_c = carry[j];
                grp_g   = gen[j];
                grp_p   = prop[j];
            end else begin
                grp_g = gen[j] | (prop[j] & grp_g);
                grp_p = prop[j] & grp_p;
            end
            carry[j+1] = grp_g | (grp_p & slice_c);
        end
    end

    assign diff      = prop ^ carry[N-1:0];
    assign carry_out = carry[N];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional macro DIV_ZERO_DETECT_EN: zero divisor short-circuits IDLE->DONE
// and raises div_zero; otherwise div_zero is tied low.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned W = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_zero
);

    localparam int unsigned CW = clog2(W);
    localparam int unsigned SW = W + 1;

    state_t         state_q, state_d;
    logic [W-1:0]   dvd_q, dvd_d;
    logic [W-1:0]   dsr_q, dsr_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   quot_d, remd_d;
    logic           busy_d, done_d;

    logic [SW-1:0]  rem_shift;
    logic [SW-1:0]  trial_diff;
    logic           no_borrow;
    logic [W-1:0]   rem_next;
    logic [W-1:0]   dvd_next;
    logic           unused_diff_msb;

    // Trial subtraction of the divisor from the shifted partial remainder.
    assign rem_shift = {rem_q, dvd_q[W-1]};

    cla_subtractor #(
        .N (SW)
    ) u_sub (
        .a         (rem_shift),
        .b         ({1'b0, dsr_q}),
        .diff      (trial_diff),
        .carry_out (no_borrow)
    );

    // Restore on borrow; the quotient bit shifts into the dividend register LSB.
    assign rem_next        = no_borrow ? trial_diff[W-1:0] : rem_shift[W-1:0];
    assign dvd_next        = {dvd_q[W-2:0], no_borrow};
    assign unused_diff_msb = trial_diff[W];

`ifdef DIV_ZERO_DETECT_EN
    logic dz_q, dz_d;
    assign div_zero = dz_q;
`else
    assign div_zero = 1'b0;
`endif

    // Next-state, datapath and output decode.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        quot_d  = quotient;
        remd_d  = remainder;
`ifdef DIV_ZERO_DETECT_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dsr_d   = divisor;
                    rem_d   = '0;
                    cnt_d   = CW'(W - 1);
                    state_d = CALC;
`ifdef DIV_ZERO_DETECT_EN
                    dz_d    = 1'b0;
                    if (divisor == '0) begin
                        quot_d  = '1;
                        remd_d  = dividend;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            CALC: begin
                dvd_d = dvd_next;
                rem_d = rem_next;
                if (cnt_q == '0) begin
                    quot_d  = dvd_next;
                    remd_d  = rem_next;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_ZERO_DETECT_EN
            dz_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            busy      <= busy_d;
            done      <= done_d;
            quotient  <= quot_d;
            remainder <= remd_d;
`ifdef DIV_ZERO_DETECT_EN
            dz_q      <= dz_d;
`endif
        end
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential unsigned restoring divider for the calculator datapath, the inverse of the multiplier path. It divides a W-bit dividend by a W-bit divisor and produces one quotient bit per clock. Each trial subtraction uses a carry-lookahead subtractor built from 4-bit lookahead slices. A start/busy/done handshake connects it to the calculator control FSM.

## Interface
Parameters:
- W, 8: operand, quotient and remainder width; must be a multiple of 4, range 4–32.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: request a division; sampled only in IDLE.
- dividend, input, W: numerator; captured on the accepted start edge.
- divisor, input, W: denominator; captured on the accepted start edge.
- busy, output, 1: high from the cycle after an accepted start through the DONE cycle.
- done, output, 1: one-cycle pulse when quotient and remainder are valid.
- quotient, output, W: result; held until the next accepted start.
- remainder, output, W: result; held until the next accepted start.
- div_zero, output, 1: divide-by-zero flag, valid with done; held like the results.

## Operation
- States:
  - IDLE: start=1 loads dvd_q=dividend, dsr_q=divisor, rem_q=0, cnt=W-1, then goes to CALC.
  - CALC: one iteration per cycle.
    - rem_shift = {rem_q[W-1:0], dvd_q[W-1]}, which is W+1 bits.
    - diff = rem_shift − {1'b0, dsr_q}, computed as rem_shift + ~dsr + 1 through the subtractor.
    - carry_out=1 means no borrow: rem_q=diff and the quotient bit is 1.
    - Otherwise: rem_q=rem_shift and the quotient bit is 0.
    - dvd_q shifts left with the quotient bit entering at the LSB.
    - When cnt=0, the final iteration's results are written into quotient/remainder and the state goes to DONE; otherwise cnt decrements.
  - DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- A start asserted while busy (CALC or DONE) is ignored and not queued.
- All arithmetic is unsigned. The remainder is always < divisor when the divisor is nonzero. rem_q[W] is 0 after every iteration.
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_zero=0, state=IDLE.
- Reset during CALC or DONE aborts the operation. Outputs are zeroed, no done pulse is issued, and a start on the first cycle after reset is accepted.
- Operand inputs may change freely after the start edge.

## Timing
- Accepted start at edge T0 → CALC occupies edges T1..TW → DONE is visible in the cycle after edge TW. done rises W+1 cycles after start was sampled.
- The earliest next start is sampled in the IDLE cycle following DONE. Back-to-back throughput is one result per W+2 cycles.
- The subtraction is combinational within one cycle; the critical path is a W-bit lookahead chain.

## Configuration
- DIV_ZERO_DETECT_EN defined: divisor==0 at start goes IDLE→DONE directly, skipping CALC.
  - Results: quotient=all ones, remainder=dividend, div_zero=1.
  - done is visible 1 cycle after start is sampled.
- DIV_ZERO_DETECT_EN undefined:
  - div_zero is tied to 0.
  - A zero divisor runs the full W iterations and naturally yields quotient=all ones, remainder=dividend with normal latency.

## Structure
- Package div_pkg holds:
  - the state enum {IDLE, CALC, DONE};
  - the default width constant DIV_W=8;
  - the counter width function clog2(W).
- Sub-module cla_subtractor (W+1 bits) computes the trial subtraction. It is built by chaining 4-bit carry-lookahead slices with carry-in=1 and ~B. It outputs diff and carry_out, where carry_out=1 means no borrow.
- The top level contains the FSM, the counter, and the dvd_q, dsr_q and rem_q registers.

## Test plan
- W=8: dividend=100, divisor=7 → done 9 cycles after start; quotient=14, remainder=2, div_zero=0.
- dividend=255, divisor=1 → quotient=255, remainder=0. Then dividend=5, divisor=9 → quotient=0, remainder=5.
- dividend=200, divisor=0:
  - With DIV_ZERO_DETECT_EN: done after 1 cycle, quotient=0xFF, remainder=200, div_zero=1.
  - Without it: done after 9 cycles with the same quotient and remainder, and div_zero=0.
- start held high with new operands (50/3) during CALC of 100/7 → first result 14 r 2 is unaffected. The next start, sampled in IDLE, yields 16 r 2.
- rst pulsed on the 4th CALC cycle → next cycle busy=0, done=0, quotient=0, remainder=0. No done pulse follows, and an immediate start 9/4 yields 2 r 1.
- Random sweep of 10,000 operand pairs with nonzero divisor → quotient*divisor+remainder==dividend and remainder<divisor. Each done pulse is exactly 1 cycle wide.
